// File: rtl/mc_pkg.sv
// Shared constants and types for the pll_clock-side multi-clock datapath blocks.
package mc_pkg;

  localparam int MC_BEAT_W = 32;
  localparam int MC_WCNT_W = 16;

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_e;

endpackage

// File: rtl/mc_word_buf2.sv
// Two-entry double-width valid/ready buffer; a pushed word is readable the cycle after the push.
// wr_ready drops when both entries are held; a pop frees a slot only from the next cycle.
module mc_word_buf2 #(
  parameter int DW = 64
) (
  input  logic          pll_clock,
  input  logic          reset_n,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_pop
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  // in_ready depends only on count, never on the consumer side
  assign wr_ready = reset_n & (count != 2'd2);
  assign rd_valid = (count != 2'd0);
  assign rd_data  = mem[rd_ptr];
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_pop & rd_valid;

  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mc_data_serialize.sv
// Splits buffered double-width words into two single-width beats on consecutive accepted cycles.
// First beat appears one cycle after push into an empty buffer; out_ready low freezes the current beat.
module mc_data_serialize
  import mc_pkg::*;
#(
  parameter int WIDTH     = MC_BEAT_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 pll_clock,
  input  logic                 reset_n,
  input  logic [2*WIDTH-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [MC_WCNT_W-1:0] word_count
);

  logic [2*WIDTH-1:0]   buf_data;
  logic                 buf_valid;
  logic                 buf_pop;
  logic                 beat_acc;
  logic                 upper_sel;
  half_e                half_q;
  half_e                half_d;
  logic [MC_WCNT_W-1:0] word_count_q;

  mc_word_buf2 #(
    .DW (2*WIDTH)
  ) u_buf (
    .pll_clock (pll_clock),
    .reset_n   (reset_n),
    .wr_data   (in_data),
    .wr_valid  (in_valid),
    .wr_ready  (in_ready),
    .rd_data   (buf_data),
    .rd_valid  (buf_valid),
    .rd_pop    (buf_pop)
  );

  assign beat_acc = buf_valid & out_ready;

  always_comb begin
    half_d  = half_q;
    buf_pop = 1'b0;
    if (beat_acc) begin
      if (half_q == HALF_LO) begin
        half_d = HALF_HI;
      end else begin
        half_d  = HALF_LO;
        buf_pop = 1'b1;
      end
    end
  end

  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      half_q <= HALF_LO;
    end else begin
      half_q <= half_d;
    end
  end

  // Second beat takes the upper half when low-half-first, and vice versa
  assign upper_sel = LSB_FIRST ? (half_q == HALF_HI) : (half_q == HALF_LO);

  always_comb begin
    out_data = '0;
    if (buf_valid) begin
      out_data = upper_sel ? buf_data[2*WIDTH-1:WIDTH] : buf_data[WIDTH-1:0];
    end
  end

  assign out_valid = buf_valid;
  assign out_last  = buf_valid & (half_q == HALF_HI);

  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      word_count_q <= '0;
    end else if (buf_pop) begin
      word_count_q <= word_count_q + 1'b1;
    end
  end

  assign word_count = word_count_q;

endmodule

// File: tb/tb_mc_data_serialize.sv
// Bench for mc_data_serialize: directed scenarios plus random traffic against a beat-queue model.
module tb_mc_data_serialize;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] word_count;

  logic [63:0] in_data1;
  logic        in_valid1;
  logic        in_ready1;
  logic [31:0] out_data1;
  logic        out_valid1;
  logic        out_ready1;
  logic        out_last1;
  logic [15:0] word_count1;

  int checks = 0;
  int errors = 0;

  // Model: beats still to be emitted, in order, and the count of finished words
  logic [31:0] mq[$];
  logic [15:0] m_wc;

  mc_data_serialize #(.WIDTH(32), .LSB_FIRST(1'b1)) dut0 (
    .pll_clock(clk), .reset_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .word_count(word_count)
  );

  mc_data_serialize #(.WIDTH(32), .LSB_FIRST(1'b0)) dut1 (
    .pll_clock(clk), .reset_n(rst_n),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_last(out_last1), .word_count(word_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_in_ready();
    return (rst_n === 1'b1) && (((mq.size() + 1) / 2) < 2);
  endfunction

  function automatic bit m_out_valid();
    return mq.size() != 0;
  endfunction

  function automatic logic [31:0] m_out_data();
    return (mq.size() != 0) ? mq[0] : 32'h0;
  endfunction

  function automatic bit m_out_last();
    return (mq.size() % 2) == 1;
  endfunction

  // Drives one cycle of inputs on dut0 and advances the model; returns at posedge+1
  task automatic cycle(input logic v, input logic [63:0] d, input logic r);
    bit do_push;
    bit do_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    do_push   = (v === 1'b1) && m_in_ready();
    do_pop    = m_out_valid() && (r === 1'b1);
    @(posedge clk);
    if (do_pop) begin
      if (m_out_last()) m_wc = m_wc + 16'd1;
      void'(mq.pop_front());
    end
    if (do_push) begin
      mq.push_back(d[31:0]);
      mq.push_back(d[63:32]);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_data    = 'x;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    in_data1   = '0;
    out_ready1 = 1'b1;
    mq.delete();
    m_wc = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (word_count !== 16'h0) begin errors++; $display("FAIL reset_word_count: got %h expected 0", word_count); end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_single();
    cycle(1'b1, 64'hAAAA_BBBB_1111_2222, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h1111_2222 || out_last !== 1'b0) begin
      errors++; $display("FAIL single_beat0: got v=%b d=%h l=%b expected v=1 d=11112222 l=0", out_valid, out_data, out_last); end
    cycle(1'b0, 'x, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hAAAA_BBBB || out_last !== 1'b1) begin
      errors++; $display("FAIL single_beat1: got v=%b d=%h l=%b expected v=1 d=aaaabbbb l=1", out_valid, out_data, out_last); end
    cycle(1'b0, 'x, 1'b1);
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL single_idle: got v=%b d=%h expected v=0 d=0", out_valid, out_data); end
    checks++; if (word_count !== m_wc) begin errors++; $display("FAIL single_wc: got %0d expected %0d", word_count, m_wc); end
  endtask

  task automatic test_stream();
    logic [15:0] wc0;
    logic [63:0] w;
    logic [31:0] exp_beat;
    int          gaps;
    gaps = 0;
    wc0  = m_wc;
    for (int i = 0; i < 16; i++) begin
      w = {32'h0000_0100 + 32'(i / 2 + 1), 32'(i / 2 + 1)};
      cycle((i % 2) == 0, (i % 2) == 0 ? w : 64'hx, 1'b1);
      exp_beat = (i % 2 == 0) ? 32'(i / 2 + 1) : 32'h0000_0100 + 32'(i / 2 + 1);
      if (out_valid !== 1'b1) gaps++;
      checks++; if (out_data !== exp_beat || out_last !== ((i % 2) == 1)) begin
        errors++; $display("FAIL stream_beat%0d: got d=%h l=%b expected d=%h l=%b", i, out_data, out_last, exp_beat, (i % 2) == 1); end
    end
    checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d bubbles expected 0", gaps); end
    cycle(1'b0, 'x, 1'b1);
    checks++; if (out_valid !== 1'b0 || word_count !== wc0 + 16'd8) begin
      errors++; $display("FAIL stream_end: got v=%b wc=%0d expected v=0 wc=%0d", out_valid, word_count, wc0 + 16'd8); end
  endtask

  task automatic test_backpressure();
    logic [63:0] w[2];
    logic [63:0] d;
    logic [31:0] exp_seq[3];
    int          n;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      d = m_in_ready() ? {$urandom, $urandom} : 64'hx;
      if (m_in_ready() && n < 2) begin w[n] = d; n++; end
      cycle(1'b1, d, 1'b0);
      checks++; if (in_ready !== m_in_ready() || out_data !== w[0][31:0] || out_last !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got rdy=%b d=%h l=%b expected rdy=%b d=%h l=0", i, in_ready, out_data, out_last, m_in_ready(), w[0][31:0]); end
    end
    checks++; if (in_ready !== 1'b0 || n != 2) begin errors++; $display("FAIL bp_full: got rdy=%b pushes=%0d expected rdy=0 pushes=2", in_ready, n); end
    exp_seq[0] = w[0][63:32];
    exp_seq[1] = w[1][31:0];
    exp_seq[2] = w[1][63:32];
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 'x, 1'b1);
      if (k < 3) begin
        checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[k]) begin
          errors++; $display("FAIL bp_drain%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, exp_seq[k]); end
      end else begin
        checks++; if (out_valid !== 1'b0 || word_count !== m_wc) begin
          errors++; $display("FAIL bp_done: got v=%b wc=%0d expected v=0 wc=%0d", out_valid, word_count, m_wc); end
      end
    end
  endtask

  task automatic test_msb_first();
    in_valid1 = 1'b1;
    in_data1  = 64'h0000_0001_0000_0002;
    out_ready1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    in_data1  = 'x;
    checks++; if (out_valid1 !== 1'b1 || out_data1 !== 32'h0000_0001 || out_last1 !== 1'b0) begin
      errors++; $display("FAIL msb_beat0: got v=%b d=%h l=%b expected v=1 d=00000001 l=0", out_valid1, out_data1, out_last1); end
    @(posedge clk);
    #1;
    checks++; if (out_data1 !== 32'h0000_0002 || out_last1 !== 1'b1) begin
      errors++; $display("FAIL msb_beat1: got d=%h l=%b expected d=00000002 l=1", out_data1, out_last1); end
    @(posedge clk);
    #1;
    checks++; if (out_valid1 !== 1'b0 || word_count1 !== 16'd1) begin
      errors++; $display("FAIL msb_end: got v=%b wc=%0d expected v=0 wc=1", out_valid1, word_count1); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1);
    cycle(1'b1, 64'hCAFE_F00D_0BAD_BEEF, 1'b1);
    cycle(1'b0, 'x, 1'b1);
    cycle(1'b0, 'x, 1'b1);
    checks++; if (out_last !== 1'b1 || out_data !== 32'hCAFE_F00D || word_count !== m_wc) begin
      errors++; $display("FAIL mid_pre: got l=%b d=%h wc=%0d expected l=1 d=cafef00d wc=%0d", out_last, out_data, word_count, m_wc); end
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_wc = 16'd0;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_async: got v=%b d=%h rdy=%b expected v=0 d=0 rdy=0", out_valid, out_data, in_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (word_count !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_release: got wc=%0d v=%b rdy=%b expected wc=0 v=0 rdy=1", word_count, out_valid, in_ready); end
    cycle(1'b1, 64'h5555_6666_7777_8888, 1'b0);
    checks++; if (out_data !== 32'h7777_8888 || out_last !== 1'b0) begin
      errors++; $display("FAIL mid_new: got d=%h l=%b expected d=77778888 l=0", out_data, out_last); end
    repeat (3) cycle(1'b0, 'x, 1'b1);
  endtask

  task automatic test_wrap();
    force dut0.word_count_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut0.word_count_q;
    m_wc = 16'hFFFE;
    for (int j = 0; j < 2; j++) begin
      cycle(1'b1, {$urandom, $urandom}, 1'b1);
      cycle(1'b0, 'x, 1'b1);
      cycle(1'b0, 'x, 1'b1);
      checks++; if (word_count !== m_wc) begin
        errors++; $display("FAIL wrap%0d: got %0d expected %0d", j, word_count, m_wc); end
    end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", word_count); end
  endtask

  task automatic test_random();
    logic v;
    logic r;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 3) != 0);
      cycle(v, v ? {$urandom, $urandom} : 64'hx, r);
      checks++; if (in_ready !== m_in_ready() || out_valid !== m_out_valid() || out_data !== m_out_data()
                    || out_last !== m_out_last() || word_count !== m_wc) begin
        errors++;
        $display("FAIL rand%0d: got rdy=%b v=%b d=%h l=%b wc=%0d expected rdy=%b v=%b d=%h l=%b wc=%0d",
                 i, in_ready, out_valid, out_data, out_last, word_count,
                 m_in_ready(), m_out_valid(), m_out_data(), m_out_last(), m_wc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_msb_first();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
